serial_operand_serializer: RTL and testbench

SERIAL_OPERAND_SERIALIZER -- requirements
Module: serial_operand_serializer

---
 rtl/serial_operand_serializer_if.sv | 24 ++
 rtl/serial_operand_serializer.sv | 168 ++++++++++++++++
 tb/tb_serial_operand_serializer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_operand_serializer_if.sv
// Parallel operand handshake plus serial bit bus between a producer and the serializer.
interface serial_operand_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;
    logic             cmp_clr;
    logic             a_bit;
    logic             b_bit;
    logic             bit_valid;
    logic             last;

    modport master (
        output in_valid, a_word, b_word,
        input  in_ready, cmp_clr, a_bit, b_bit, bit_valid, last
    );

    modport slave (
        input  in_valid, a_word, b_word,
        output in_ready, cmp_clr, a_bit, b_bit, bit_valid, last
    );
endinterface

// File: rtl/serial_operand_serializer.sv
// Captures an operand pair and streams it bit-serially to a serial comparator,
// preceded by a one-cycle comparator clear. Define SERIALIZER_LSB_FIRST_EN for LSB-first order.
module serial_operand_serializer #(
    parameter int WIDTH = 8
) (
    input logic                        clk,
    input logic                        rst,
    serial_operand_serializer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam int            CW         = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_cmp_clr;
    logic             r_a_bit;
    logic             r_b_bit;
    logic             r_bit_valid;
    logic             r_last;

    logic [WIDTH-1:0] w_a_sh_nxt;
    logic [WIDTH-1:0] w_b_sh_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_cmp_clr_nxt;
    logic             w_a_bit_nxt;
    logic             w_b_bit_nxt;
    logic             w_bit_valid_nxt;
    logic             w_last_nxt;
    logic             w_accept;
    logic             w_a_head;
    logic             w_b_head;
    logic [WIDTH-1:0] w_a_adv;
    logic [WIDTH-1:0] w_b_adv;

    // Head bit and post-shift value select the transmission order.
`ifdef SERIALIZER_LSB_FIRST_EN
    assign w_a_head = r_a_sh[0];
    assign w_b_head = r_b_sh[0];
    assign w_a_adv  = {1'b0, r_a_sh[WIDTH-1:1]};
    assign w_b_adv  = {1'b0, r_b_sh[WIDTH-1:1]};
`else
    assign w_a_head = r_a_sh[WIDTH-1];
    assign w_b_head = r_b_sh[WIDTH-1];
    assign w_a_adv  = {r_a_sh[WIDTH-2:0], 1'b0};
    assign w_b_adv  = {r_b_sh[WIDTH-2:0], 1'b0};
`endif

    assign w_accept     = bus.in_valid && (r_state == ST_IDLE);
    assign bus.in_ready = (r_state == ST_IDLE);
    assign bus.cmp_clr  = r_cmp_clr;
    assign bus.a_bit    = r_a_bit;
    assign bus.b_bit    = r_b_bit;
    assign bus.bit_valid = r_bit_valid;
    assign bus.last     = r_last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: w_state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values: outputs are computed one cycle early so they can be registered.
    always_comb begin
        w_a_sh_nxt      = r_a_sh;
        w_b_sh_nxt      = r_b_sh;
        w_cnt_nxt       = r_cnt;
        w_cmp_clr_nxt   = 1'b0;
        w_a_bit_nxt     = 1'b0;
        w_b_bit_nxt     = 1'b0;
        w_bit_valid_nxt = 1'b0;
        w_last_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_a_sh_nxt    = bus.a_word;
                    w_b_sh_nxt    = bus.b_word;
                    w_cmp_clr_nxt = 1'b1;
                end else begin
                    w_a_sh_nxt = r_a_sh;
                    w_b_sh_nxt = r_b_sh;
                end
            end
            ST_CLEAR: begin
                w_a_bit_nxt     = w_a_head;
                w_b_bit_nxt     = w_b_head;
                w_bit_valid_nxt = 1'b1;
                w_a_sh_nxt      = w_a_adv;
                w_b_sh_nxt      = w_b_adv;
                w_cnt_nxt       = {CW{1'b0}};
            end
            ST_SHIFT: begin
                if (r_cnt != CNT_LAST) begin
                    w_a_bit_nxt     = w_a_head;
                    w_b_bit_nxt     = w_b_head;
                    w_bit_valid_nxt = 1'b1;
                    w_last_nxt      = (r_cnt == CNT_PENULT);
                    w_a_sh_nxt      = w_a_adv;
                    w_b_sh_nxt      = w_b_adv;
                    w_cnt_nxt       = r_cnt + CW'(1);
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            default: begin
                w_cnt_nxt = {CW{1'b0}};
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh      <= {WIDTH{1'b0}};
            r_b_sh      <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_cmp_clr   <= 1'b0;
            r_a_bit     <= 1'b0;
            r_b_bit     <= 1'b0;
            r_bit_valid <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_a_sh      <= w_a_sh_nxt;
            r_b_sh      <= w_b_sh_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmp_clr   <= w_cmp_clr_nxt;
            r_a_bit     <= w_a_bit_nxt;
            r_b_bit     <= w_b_bit_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_last      <= w_last_nxt;
        end
    end
endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench for serial_operand_serializer (WIDTH=8 and WIDTH=2) with a downstream serial comparator model.
module tb_serial_operand_serializer;
`ifdef SERIALIZER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    typedef struct {
        logic [7:0] a_got;
        logic [7:0] b_got;
        logic [7:0] a_stream;
        logic [7:0] b_stream;
        int         clr_at;
        int         first_at;
        int         last_at;
        int         ready_at;
        int         n_valid;
        int         n_last;
        int         n_clr;
        int         n_busy;
        logic       gt;
        logic       eq;
        logic       lt;
    } obs_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_operand_serializer_if #(.WIDTH(8)) if8 ();
    serial_operand_serializer_if #(.WIDTH(2)) if2 ();

    serial_operand_serializer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_operand_serializer #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream serial comparator; cmp_clr is its reset. MSB-first locks on the first difference,
    // LSB-first lets every later difference override.
    logic r_cmp_dec, r_cmp_gt, r_cmp_lt;
    logic w_gt, w_lt, w_eq;
    always_ff @(posedge clk) begin
        if (if8.cmp_clr) begin
            r_cmp_dec <= 1'b0;
            r_cmp_gt  <= 1'b0;
            r_cmp_lt  <= 1'b0;
        end else if (if8.bit_valid && (LSB_FIRST || !r_cmp_dec) && (if8.a_bit != if8.b_bit)) begin
            r_cmp_dec <= 1'b1;
            r_cmp_gt  <= if8.a_bit;
            r_cmp_lt  <= if8.b_bit;
        end
    end
    always_comb begin
        w_gt = r_cmp_gt;
        w_lt = r_cmp_lt;
        if (if8.bit_valid && (LSB_FIRST || !r_cmp_dec) && (if8.a_bit != if8.b_bit)) begin
            w_gt = if8.a_bit;
            w_lt = if8.b_bit;
        end
        w_eq = !w_gt && !w_lt;
    end

    function automatic logic [7:0] bb_a(input int i);
        return 8'(i * 37 + 5);
    endfunction
    function automatic logic [7:0] bb_b(input int i);
        return 8'(i * 91 + 200);
    endfunction

    // Offer one pair to the WIDTH=8 instance, scramble operands afterwards, observe 14 cycles.
    task automatic run_frame8(input logic [7:0] a, input logic [7:0] b, output obs_t o);
        int idx;
        o = '{a_got: 8'h00, b_got: 8'h00, a_stream: 8'h00, b_stream: 8'h00, clr_at: -1,
              first_at: -1, last_at: -1, ready_at: -1, n_valid: 0, n_last: 0, n_clr: 0,
              n_busy: 0, gt: 1'b0, eq: 1'b0, lt: 1'b0};
        @(posedge clk); #1;
        if8.in_valid = 1'b1;
        if8.a_word   = a;
        if8.b_word   = b;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            if8.a_word = 8'($urandom);
            if8.b_word = 8'($urandom);
            @(negedge clk);
            if (if8.cmp_clr) begin
                o.n_clr++;
                if (o.clr_at < 0) o.clr_at = n;
            end
            if (if8.bit_valid) begin
                if (o.first_at < 0) o.first_at = n;
                if (o.n_valid < 8) begin
                    o.a_stream[7 - o.n_valid] = if8.a_bit;
                    o.b_stream[7 - o.n_valid] = if8.b_bit;
                    idx = LSB_FIRST ? o.n_valid : 7 - o.n_valid;
                    o.a_got[idx] = if8.a_bit;
                    o.b_got[idx] = if8.b_bit;
                end
                o.n_valid++;
            end
            if (if8.last) begin
                o.n_last++;
                o.last_at = n;
                o.gt = w_gt;
                o.eq = w_eq;
                o.lt = w_lt;
            end
            if (!if8.in_ready) o.n_busy++;
            else if (o.ready_at < 0) o.ready_at = n;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if8.in_valid = 1'b1;
        if2.in_valid = 1'b1;
        if8.a_word = 8'hFF; if8.b_word = 8'hFF;
        if2.a_word = 2'b11; if2.b_word = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        if8.in_valid = 1'b0;
        if2.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", if8.in_ready); end
        n_checks++; if (if8.cmp_clr !== 1'b0) begin n_fail++; $display("FAIL reset_cmp_clr got=%b exp=0 (rst over in_valid)", if8.cmp_clr); end
        n_checks++; if (if8.bit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bit_valid got=%b exp=0", if8.bit_valid); end
        n_checks++; if (if8.last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", if8.last); end
        n_checks++; if ({if8.a_bit, if8.b_bit} !== 2'b00) begin n_fail++; $display("FAIL reset_bits got=%b exp=00", {if8.a_bit, if8.b_bit}); end
        n_checks++; if ({if2.in_ready, if2.cmp_clr, if2.bit_valid} !== 3'b100) begin n_fail++; $display("FAIL reset_w2 got=%b exp=100", {if2.in_ready, if2.cmp_clr, if2.bit_valid}); end
    endtask

    task automatic test_basic_a5();
        obs_t o;
        run_frame8(8'hA5, 8'h3C, o);
        n_checks++; if (o.a_stream !== 8'hA5) begin n_fail++; $display("FAIL a5_a_stream got=%b exp=10100101", o.a_stream); end
        n_checks++; if (o.b_stream !== 8'h3C) begin n_fail++; $display("FAIL a5_b_stream got=%b exp=00111100", o.b_stream); end
        n_checks++; if (o.clr_at !== 1) begin n_fail++; $display("FAIL a5_clr_at got=%0d exp=1", o.clr_at); end
        n_checks++; if (o.n_clr !== 1) begin n_fail++; $display("FAIL a5_clr_count got=%0d exp=1", o.n_clr); end
        n_checks++; if (o.first_at !== 2) begin n_fail++; $display("FAIL a5_first_bit_at got=%0d exp=2", o.first_at); end
        n_checks++; if (o.n_valid !== 8) begin n_fail++; $display("FAIL a5_valid_count got=%0d exp=8", o.n_valid); end
        n_checks++; if (o.last_at !== 9 || o.n_last !== 1) begin n_fail++; $display("FAIL a5_last got_at=%0d got_n=%0d exp_at=9 exp_n=1", o.last_at, o.n_last); end
        n_checks++; if (o.n_busy !== 9) begin n_fail++; $display("FAIL a5_ready_low got=%0d exp=9", o.n_busy); end
        n_checks++; if (o.ready_at !== 10) begin n_fail++; $display("FAIL a5_ready_again got=%0d exp=10", o.ready_at); end
        n_checks++; if (o.gt !== 1'b1) begin n_fail++; $display("FAIL a5_cmp_gt got=%b exp=1", o.gt); end
    endtask

    task automatic test_comparator();
        logic [7:0] pa [3];
        logic [7:0] pb [3];
        logic [2:0] pr [3];
        obs_t o;
        pa[0] = 8'h80; pb[0] = 8'h7F; pr[0] = 3'b100;
        pa[1] = 8'h12; pb[1] = 8'h12; pr[1] = 3'b010;
        pa[2] = 8'h00; pb[2] = 8'hFF; pr[2] = 3'b001;
        for (int k = 0; k < 3; k++) begin
            run_frame8(pa[k], pb[k], o);
            n_checks++; if ({o.a_got, o.b_got} !== {pa[k], pb[k]}) begin n_fail++; $display("FAIL cmp_data[%0d] got=%h/%h exp=%h/%h", k, o.a_got, o.b_got, pa[k], pb[k]); end
            n_checks++; if ({o.gt, o.eq, o.lt} !== pr[k]) begin n_fail++; $display("FAIL cmp_result[%0d] got=%b exp=%b (gt,eq,lt)", k, {o.gt, o.eq, o.lt}, pr[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fa [4];
        logic [7:0] fb [4];
        int         fl [4];
        logic [7:0] cur_a, cur_b;
        int         nf, nb, idx;
        nf = 0; nb = 0; cur_a = 8'h00; cur_b = 8'h00;
        for (int k = 0; k < 4; k++) begin fa[k] = 8'h00; fb[k] = 8'h00; fl[k] = -1; end
        @(posedge clk); #1;
        for (int i = 0; i < 41; i++) begin
            if8.in_valid = (i < 30);
            if8.a_word = bb_a(i);
            if8.b_word = bb_b(i);
            @(negedge clk);
            if (if8.bit_valid) begin
                idx = LSB_FIRST ? nb : 7 - nb;
                if (nb < 8) begin cur_a[idx] = if8.a_bit; cur_b[idx] = if8.b_bit; end
                nb++;
            end
            if (if8.last) begin
                if (nf < 4) begin fa[nf] = cur_a; fb[nf] = cur_b; fl[nf] = i; end
                nf++;
                nb = 0;
            end
            @(posedge clk); #1;
        end
        if8.in_valid = 1'b0;
        n_checks++; if (nf !== 3) begin n_fail++; $display("FAIL b2b_frames got=%0d exp=3", nf); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if ({fa[k], fb[k]} !== {bb_a(10 * k), bb_b(10 * k)}) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h/%h exp=%h/%h", k, fa[k], fb[k], bb_a(10 * k), bb_b(10 * k)); end
            n_checks++; if (fl[k] !== 9 + 10 * k) begin n_fail++; $display("FAIL b2b_last_cycle[%0d] got=%0d exp=%0d", k, fl[k], 9 + 10 * k); end
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_t o;
        int   nb, stray;
        bit   hit;
        nb = 0; stray = 0; hit = 1'b0;
        @(posedge clk); #1;
        if8.in_valid = 1'b1;
        if8.a_word = 8'hFF; if8.b_word = 8'hFF;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (if8.bit_valid) begin
                if (nb == 3) begin
                    rst = 1'b1;
                    hit = 1'b1;
                    break;
                end
                nb++;
            end
        end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rst_mid_bit3_seen got=%b exp=1", hit); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({if8.bit_valid, if8.in_ready, if8.last, if8.cmp_clr} !== 4'b0100) begin n_fail++; $display("FAIL rst_mid_after got=%b exp=0100 (valid,ready,last,clr)", {if8.bit_valid, if8.in_ready, if8.last, if8.cmp_clr}); end
        for (int n = 0; n < 11; n++) begin
            @(negedge clk);
            if (if8.bit_valid || if8.last || if8.cmp_clr) stray++;
        end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rst_mid_stray got=%0d exp=0", stray); end
        run_frame8(8'h01, 8'h02, o);
        n_checks++; if ({o.a_got, o.b_got} !== 16'h0102) begin n_fail++; $display("FAIL rst_new_data got=%h/%h exp=01/02", o.a_got, o.b_got); end
        n_checks++; if (o.n_valid !== 8 || o.last_at !== 9 || o.clr_at !== 1) begin n_fail++; $display("FAIL rst_new_timing got_valid=%0d got_last=%0d got_clr=%0d exp=8/9/1", o.n_valid, o.last_at, o.clr_at); end
        n_checks++; if (o.lt !== 1'b1) begin n_fail++; $display("FAIL rst_new_cmp_lt got=%b exp=1", o.lt); end
    endtask

    task automatic test_width2();
        logic [11:0] bv_m, last_m, clr_m, rdy_m;
        logic [1:0]  wa [2];
        logic [1:0]  wb [2];
        int          nf, nb, idx;
        bv_m = 12'h000; last_m = 12'h000; clr_m = 12'h000; rdy_m = 12'h000;
        nf = 0; nb = 0;
        wa[0] = 2'b00; wa[1] = 2'b00; wb[0] = 2'b00; wb[1] = 2'b00;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            if2.in_valid = (i <= 4);
            if2.a_word = 2'b10;
            if2.b_word = 2'b01;
            @(negedge clk);
            bv_m[i]   = if2.bit_valid;
            last_m[i] = if2.last;
            clr_m[i]  = if2.cmp_clr;
            rdy_m[i]  = if2.in_ready;
            if (if2.bit_valid && nf < 2 && nb < 2) begin
                idx = LSB_FIRST ? nb : 1 - nb;
                wa[nf][idx] = if2.a_bit;
                wb[nf][idx] = if2.b_bit;
                nb++;
            end
            if (if2.last) begin nf++; nb = 0; end
            @(posedge clk); #1;
        end
        if2.in_valid = 1'b0;
        n_checks++; if (bv_m !== 12'h0CC) begin n_fail++; $display("FAIL w2_bit_valid_cycles got=%b exp=%b", bv_m, 12'h0CC); end
        n_checks++; if (last_m !== 12'h088) begin n_fail++; $display("FAIL w2_last_cycles got=%b exp=%b", last_m, 12'h088); end
        n_checks++; if (clr_m !== 12'h022) begin n_fail++; $display("FAIL w2_clr_cycles got=%b exp=%b", clr_m, 12'h022); end
        n_checks++; if (rdy_m !== 12'hF11) begin n_fail++; $display("FAIL w2_ready_cycles got=%b exp=%b", rdy_m, 12'hF11); end
        n_checks++; if ({wa[0], wb[0], wa[1], wb[1]} !== 8'b10_01_10_01) begin n_fail++; $display("FAIL w2_data got=%b exp=10011001", {wa[0], wb[0], wa[1], wb[1]}); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        if8.in_valid = 1'b0; if8.a_word = 8'h00; if8.b_word = 8'h00;
        if2.in_valid = 1'b0; if2.a_word = 2'b00; if2.b_word = 2'b00;
        test_reset();
        test_basic_a5();
        test_comparator();
        test_back_to_back();
        test_reset_mid_frame();
        test_width2();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
